led_frame_composer: RTL and testbench
=====================================

LED_FRAME_COMPOSER -- requirements
Module: led_frame_composer

Interface
REQ-001 Parameter g_blink_div, default 50_000_000, is the blink half-period in clock cycles and SHALL be >= 2.
REQ-002 Parameter g_lamptest_cycles, default 100_000_000, is the lamp-test duration in clock cycles and SHALL be >= 1.
REQ-003 ClkRs_ix  input  ckrs_t  the block SHALL use one clock, ClkRs_ix.clk, and ClkRs_ix.reset SHALL be synchronous and active-high.
REQ-004 Wr_i  input  1  write strobe, one word per cycle.
REQ-005 WrAddr_ib3  input  3  word address: row = [2:1], state = [0].
REQ-006 WrData_ib16  input  16  word data, one bit per column.
REQ-007 WrBlink_i  input  1  when 1, the write targets the shadow blink mask; when 0, it targets the shadow data.
REQ-008 Commit_i  input  1  copy both shadow buffers to the active buffers.
REQ-009 LampTest_i  input  1  (re)start lamp test.
REQ-010 Ack_o  output  1  single-cycle write acknowledge.
REQ-011 ledData_ob  output  128  led_frame_t ([3:0][1:0][15:0]), the frame feeding the tlc5920 driver.
REQ-012 BlinkPhase_o  output  1  current blink phase.
REQ-013 LampTestActive_o  output  1  high while the FSM is in s_LampTest.

Function
REQ-014 The block SHALL accept every Wr_i cycle (no backpressure) and SHALL assert Ack_o for exactly one cycle, 1 clock after each accepted write.
REQ-015 A write SHALL update only the addressed 16-bit word of the shadow data, or of the shadow blink mask, at the clock edge where Wr_i is sampled.
REQ-016 On Commit_i, the block SHALL copy the shadow data and the shadow blink mask into the active buffers at the same edge; shadow contents SHALL be preserved.
REQ-017 If Wr_i and Commit_i occur in the same cycle, the commit SHALL use the pre-write shadow and the write SHALL land in the shadow only.
REQ-018 The blink counter SHALL count 0..g_blink_div-1, and on wrap it SHALL reset to 0 and toggle BlinkPhase_o.
REQ-019 In s_Normal, ledData_ob SHALL register active_data AND NOT(active_blink AND {128{BlinkPhase}}), giving 1-cycle latency from commit or phase toggle to output.
REQ-020 In s_LampTest, ledData_ob SHALL be all ones, registered with 1-cycle latency.
REQ-021 The FSM SHALL have two states, s_LampTest and s_Normal; reset SHALL enter s_LampTest with the counter loaded to g_lamptest_cycles-1.
REQ-022 In s_LampTest, the counter SHALL decrement each cycle, and at 0 the FSM SHALL go to s_Normal on the next edge.
REQ-023 LampTest_i asserted in s_Normal SHALL enter s_LampTest and reload the counter.
REQ-024 LampTest_i asserted in s_LampTest SHALL reload the counter, extending the test.
REQ-025 Writes and commits during s_LampTest SHALL be accepted and acknowledged normally, and SHALL become visible on the first s_Normal output cycle.
REQ-026 The blink counter SHALL run in both states.

Reset
REQ-027 On reset, shadow data, shadow blink, active data, active blink, blink counter, BlinkPhase_o and Ack_o SHALL be 0.
REQ-028 On reset, ledData_ob SHALL be 0 on the reset cycle and all ones from the following cycle (lamp test), and LampTestActive_o SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard pending writes, commits and lamp-test progress without glitching beyond the values in REQ-027 and REQ-028.

Structure
REQ-030 led_frame_t, the FSM state enum and the row/state/column count constants (4/2/16) SHALL reside in shared package McoiDisplayPkg, next to the tlc5920 types.
REQ-031 The blink divider SHALL be a sub-module, led_blink_gen (clock/reset, parameter g_blink_div, output phase); all other logic SHALL be in the top module.

Verification (bench overrides: g_blink_div=4, g_lamptest_cycles=8)
REQ-032 Release reset and leave inputs idle -> LampTestActive_o=1 and ledData_ob=all ones for 8 cycles, then ledData_ob=0 and LampTestActive_o=0.
REQ-033 After lamp test, write addr 3'b101 data 16'hA5A5, then Commit_i -> Ack_o 1 cycle after the write; ledData_ob[2][1]=16'hA5A5 one cycle after commit; all other words 0.
REQ-034 Blink mask addr 3'b101 = 16'h00FF, then commit -> ledData_ob[2][1] alternates 16'hA5A5 / 16'hA500 every 4 cycles, in step with BlinkPhase_o.
REQ-035 Wr_i (addr 0, data 16'hFFFF) and Commit_i in the same cycle -> ledData_ob[0][0] stays 0; a second commit -> 16'hFFFF.
REQ-036 LampTest_i pulsed at cycle 5 of lamp test -> all ones persists 8 cycles after the pulse; a write and commit made during the test appears on the first s_Normal cycle.
REQ-037 Reset asserted after REQ-034 -> all buffers clear, Ack_o=0, lamp test restarts, and ledData_ob=0 after the test ends.

Source files
------------

// File: rtl/McoiDisplayPkg.sv
// Shared display types: clock/reset bundle, LED frame layout, lamp-test FSM
// states and the tlc5920 driver word.
package McoiDisplayPkg;

  localparam int unsigned c_rows   = 4;
  localparam int unsigned c_states = 2;
  localparam int unsigned c_cols   = 16;

  // Clock plus synchronous active-high reset
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  // Frame indexed [row][state][column]
  typedef logic [c_rows-1:0][c_states-1:0][c_cols-1:0] led_frame_t;

  typedef enum logic {
    s_LampTest = 1'b0,
    s_Normal   = 1'b1
  } lamp_fsm_t;

  // One serial word as shifted into the tlc5920 column driver
  typedef struct packed {
    logic [c_cols/2-1:0] data;
    logic [2:0]          addr;
    logic                latch;
    logic                blank_n;
  } tlc5920_t;

endpackage

// File: rtl/led_blink_gen.sv
// Blink divider: counts 0..g_blink_div-1 and toggles Phase_o on every wrap.
// Ports: ClkRs_ix (clock + sync reset), Phase_o (registered blink phase).
module led_blink_gen
  import McoiDisplayPkg::*;
#(
  parameter int unsigned g_blink_div = 50_000_000
) (
  input  ckrs_t ClkRs_ix,
  output logic  Phase_o
);

  localparam int unsigned cnt_w = $clog2(g_blink_div);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(g_blink_div - 1);

  logic [cnt_w-1:0] cnt;

  // Half-period counter and phase toggle
  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      cnt     <= '0;
      Phase_o <= 1'b0;
    end else if (cnt == cnt_last) begin
      cnt     <= '0;
      Phase_o <= ~Phase_o;
    end else begin
      cnt <= cnt + cnt_w'(1);
    end
  end

endmodule

// File: rtl/led_frame_composer.sv
// Double-buffered LED frame composer with blink mask and lamp test.
// Ports: ClkRs_ix clock/sync reset; Wr_i/WrAddr_ib3/WrData_ib16/WrBlink_i
// write one shadow word (data or blink mask); Commit_i copies shadow to
// active; LampTest_i (re)starts the lamp test; Ack_o write acknowledge;
// ledData_ob composed frame; BlinkPhase_o blink phase; LampTestActive_o
// flags lamp-test frames on ledData_ob.
module led_frame_composer
  import McoiDisplayPkg::*;
#(
  parameter int unsigned g_blink_div       = 50_000_000,
  parameter int unsigned g_lamptest_cycles = 100_000_000
) (
  input  ckrs_t       ClkRs_ix,
  input  logic        Wr_i,
  input  logic [2:0]  WrAddr_ib3,
  input  logic [15:0] WrData_ib16,
  input  logic        WrBlink_i,
  input  logic        Commit_i,
  input  logic        LampTest_i,
  output logic        Ack_o,
  output led_frame_t  ledData_ob,
  output logic        BlinkPhase_o,
  output logic        LampTestActive_o
);

  localparam int unsigned lt_w = $clog2(g_lamptest_cycles + 1);
  localparam logic [lt_w-1:0] lt_reload = lt_w'(g_lamptest_cycles - 1);
  localparam int unsigned frame_w = $bits(led_frame_t);

  led_frame_t      shadow_data, shadow_blink;
  led_frame_t      active_data, active_blink;
  lamp_fsm_t       state_q, state_d;
  logic [lt_w-1:0] lt_cnt_q, lt_cnt_d;
  logic [1:0]      wr_row;
  logic            wr_state;

  assign wr_row   = WrAddr_ib3[2:1];
  assign wr_state = WrAddr_ib3[0];

  led_blink_gen #(
    .g_blink_div (g_blink_div)
  ) u_blink (
    .ClkRs_ix (ClkRs_ix),
    .Phase_o  (BlinkPhase_o)
  );

  // Shadow/active buffers; commit reads the pre-write shadow at the same edge
  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      shadow_data  <= '0;
      shadow_blink <= '0;
      active_data  <= '0;
      active_blink <= '0;
    end else begin
      if (Commit_i) begin
        active_data  <= shadow_data;
        active_blink <= shadow_blink;
      end
      if (Wr_i) begin
        if (WrBlink_i) shadow_blink[wr_row][wr_state] <= WrData_ib16;
        else           shadow_data[wr_row][wr_state]  <= WrData_ib16;
      end
    end
  end

  // Lamp-test FSM state register
  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      state_q  <= s_LampTest;
      lt_cnt_q <= lt_reload;
    end else begin
      state_q  <= state_d;
      lt_cnt_q <= lt_cnt_d;
    end
  end

  // Lamp-test FSM next state; a request during the test restarts it
  always_comb begin
    state_d  = state_q;
    lt_cnt_d = lt_cnt_q;
    case (state_q)
      s_LampTest: begin
        if (LampTest_i)              lt_cnt_d = lt_reload;
        else if (lt_cnt_q == '0)     state_d  = s_Normal;
        else                         lt_cnt_d = lt_cnt_q - lt_w'(1);
      end
      s_Normal: begin
        if (LampTest_i) begin
          state_d  = s_LampTest;
          lt_cnt_d = lt_reload;
        end
      end
    endcase
  end

  // Registered outputs; LampTestActive_o tracks the frame being shown
  always_ff @(posedge ClkRs_ix.clk) begin
    if (ClkRs_ix.reset) begin
      Ack_o            <= 1'b0;
      ledData_ob       <= '0;
      LampTestActive_o <= 1'b1;
    end else begin
      Ack_o            <= Wr_i;
      LampTestActive_o <= (state_q == s_LampTest);
      if (state_q == s_LampTest) ledData_ob <= '1;
      else ledData_ob <= active_data & ~(active_blink & {frame_w{BlinkPhase_o}});
    end
  end

endmodule

// File: tb/tb_led_frame_composer.sv
// Directed bench for led_frame_composer with a per-cycle reference model
// feeding an expected-output queue, plus spot checks against literal values.
module tb_led_frame_composer;
  import McoiDisplayPkg::*;

  localparam int unsigned BLINK_DIV = 4;
  localparam int unsigned LT_CYC    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  ckrs_t       ckrs;
  logic        wr = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [15:0] data = 16'h0;
  logic        wr_blink = 1'b0;
  logic        commit = 1'b0;
  logic        lamp = 1'b0;
  logic        ack;
  led_frame_t  led;
  logic        phase;
  logic        lta;

  assign ckrs.clk   = clk;
  assign ckrs.reset = rst;

  always #5 clk = ~clk;

  led_frame_composer #(
    .g_blink_div       (BLINK_DIV),
    .g_lamptest_cycles (LT_CYC)
  ) dut (
    .ClkRs_ix         (ckrs),
    .Wr_i             (wr),
    .WrAddr_ib3       (addr),
    .WrData_ib16      (data),
    .WrBlink_i        (wr_blink),
    .Commit_i         (commit),
    .LampTest_i       (lamp),
    .Ack_o            (ack),
    .ledData_ob       (led),
    .BlinkPhase_o     (phase),
    .LampTestActive_o (lta)
  );

  typedef struct packed {
    led_frame_t led;
    logic       ack;
    logic       phase;
    logic       lta;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  led_frame_t m_sd, m_sb, m_ad, m_ab, m_led;
  int         m_bcnt, m_lcnt;
  logic       m_phase, m_lt, m_ack, m_lta;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    if (rst) begin
      m_sd = '0; m_sb = '0; m_ad = '0; m_ab = '0;
      m_bcnt = 0; m_phase = 1'b0;
      m_lt = 1'b1; m_lcnt = int'(LT_CYC) - 1;
      m_led = '0; m_ack = 1'b0; m_lta = 1'b1;
    end else begin
      m_led = m_lt ? '1 : (m_ad & ~(m_ab & {128{m_phase}}));
      m_lta = m_lt;
      m_ack = wr;
      if (commit) begin
        m_ad = m_sd;
        m_ab = m_sb;
      end
      if (wr) begin
        if (wr_blink) m_sb[addr[2:1]][addr[0]] = data;
        else          m_sd[addr[2:1]][addr[0]] = data;
      end
      if (m_bcnt == int'(BLINK_DIV) - 1) begin
        m_bcnt  = 0;
        m_phase = ~m_phase;
      end else begin
        m_bcnt++;
      end
      if (m_lt) begin
        if (lamp)             m_lcnt = int'(LT_CYC) - 1;
        else if (m_lcnt == 0) m_lt = 1'b0;
        else                  m_lcnt--;
      end else if (lamp) begin
        m_lt   = 1'b1;
        m_lcnt = int'(LT_CYC) - 1;
      end
    end
    sb_q.push_back('{led: m_led, ack: m_ack, phase: m_phase, lta: m_lta});
  endtask

  // One clock: push expectation, take the edge, pop and compare outputs
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed=0 entries expected=1");
    end else begin
      e = sb_q.pop_front();
      chk("sb_led",   128'(led),   128'(e.led));
      chk("sb_ack",   128'(ack),   128'(e.ack));
      chk("sb_phase", 128'(phase), 128'(e.phase));
      chk("sb_lta",   128'(lta),   128'(e.lta));
    end
  endtask

  initial begin
    led_frame_t exp_f;
    logic       ph;

    // Reset cycles
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_led",   128'(led),   128'(0));
    chk("rst_lta",   128'(lta),   128'(1));
    chk("rst_ack",   128'(ack),   128'(0));
    chk("rst_phase", 128'(phase), 128'(0));

    // Idle lamp test: all ones for 8 cycles, then blank frame
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("lt_ones", 128'(led), {128{1'b1}});
      chk("lt_active", 128'(lta), 128'(1));
    end
    cycle();
    chk("lt_end_led", 128'(led), 128'(0));
    chk("lt_end_lta", 128'(lta), 128'(0));

    // Write + commit one word
    wr = 1'b1; addr = 3'b101; data = 16'hA5A5; wr_blink = 1'b0;
    cycle();
    chk("ack_after_wr", 128'(ack), 128'(1));
    wr = 1'b0; commit = 1'b1;
    cycle();
    chk("ack_one_cycle", 128'(ack), 128'(0));
    commit = 1'b0;
    cycle();
    exp_f = '0;
    exp_f[2][1] = 16'hA5A5;
    chk("commit_frame", 128'(led), 128'(exp_f));

    // Blink mask on the low byte of the same word
    wr = 1'b1; addr = 3'b101; data = 16'h00FF; wr_blink = 1'b1;
    cycle();
    wr = 1'b0; wr_blink = 1'b0; commit = 1'b1;
    cycle();
    commit = 1'b0;
    cycle();
    for (int i = 0; i < 16; i++) begin
      ph = m_phase;
      cycle();
      chk("blink_word", 128'(led[2][1]), ph ? 128'(16'hA500) : 128'(16'hA5A5));
    end

    // Same-cycle write and commit: commit sees pre-write shadow
    wr = 1'b1; addr = 3'b000; data = 16'hFFFF; commit = 1'b1;
    cycle();
    wr = 1'b0; commit = 1'b0;
    cycle();
    chk("wr_commit_same", 128'(led[0][0]), 128'(16'h0000));
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    cycle();
    chk("second_commit", 128'(led[0][0]), 128'(16'hFFFF));

    // Lamp test from normal, retriggered at its 5th cycle, with write+commit inside
    lamp = 1'b1;
    cycle();
    lamp = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("lt2_ones", 128'(led), {128{1'b1}});
    end
    lamp = 1'b1;
    cycle();
    lamp = 1'b0;
    chk("lt2_retrig", 128'(led), {128{1'b1}});
    for (int k = 6; k <= 13; k++) begin
      if (k == 7) begin
        wr = 1'b1; addr = 3'b110; data = 16'h1234; wr_blink = 1'b0;
      end
      if (k == 8) commit = 1'b1;
      cycle();
      wr = 1'b0; commit = 1'b0;
      chk("lt2_extend", 128'(led), {128{1'b1}});
      chk("lt2_lta",    128'(lta), 128'(1));
    end
    cycle();
    chk("lt2_wr_visible", 128'(led[3][0]), 128'(16'h1234));
    chk("lt2_keep_word",  128'(led[0][0]), 128'(16'hFFFF));
    chk("lt2_lta_off",    128'(lta),       128'(0));

    // Mid-operation reset with a write pending
    rst = 1'b1; wr = 1'b1; addr = 3'b011; data = 16'hBEEF;
    cycle();
    chk("rst2_led",   128'(led),   128'(0));
    chk("rst2_ack",   128'(ack),   128'(0));
    chk("rst2_lta",   128'(lta),   128'(1));
    chk("rst2_phase", 128'(phase), 128'(0));
    rst = 1'b0; wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rst2_lt_ones", 128'(led), {128{1'b1}});
    end
    cycle();
    chk("rst2_cleared", 128'(led), 128'(0));
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    cycle();
    chk("rst2_shadow_clear", 128'(led), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
